// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types and segment patterns for the 7-segment scan decoder
package sseg_pkg;

    localparam int CODE_W = 6;

    typedef enum logic [1:0] {
        KIND_HEX     = 2'b00,
        KIND_NEG     = 2'b01,
        KIND_BLANK   = 2'b10,
        KIND_INVALID = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [3:0] value;
    } code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] PAT_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] PAT_NEG   = 7'b0111111;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_pattern_decode.sv
// rtl/sseg_pattern_decode.sv - combinational segment pattern to {kind, value} decoder
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output code_t      code_o
);

    always_comb begin
        code_o.kind  = KIND_INVALID;
        code_o.value = 4'd0;
        if (pattern_i == PAT_NEG) begin
            code_o.kind = KIND_NEG;
        end else if (pattern_i == PAT_BLANK) begin
            code_o.kind = KIND_BLANK;
        end
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == PAT_HEX[i]) begin
                code_o.kind  = KIND_HEX;
                code_o.value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - multiplexed 7-segment bus monitor producing one frame per complete scan
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [6:0]                   seg_in,
    input  logic [NUM_DIGITS-1:0]        sel_n_in,
    output logic [CODE_W*NUM_DIGITS-1:0] out_digits,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun,
    output logic                         any_invalid
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    logic [6:0]                   seg_meta_q, seg_sync_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]        sel_meta_q, sel_sync_q, sel_prev_q;
    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]        mask_q, mask_d;
    logic [CODE_W*NUM_DIGITS-1:0] slots_q, slots_d;
    logic [CODE_W*NUM_DIGITS-1:0] out_digits_q;
    logic                         out_valid_q, overrun_q, any_invalid_q;

    logic [NUM_DIGITS-1:0] sel_act;
    logic                  onehot, same, capture, frame_load, any_inv_d;
    logic [IDX_W-1:0]      sel_idx;
    code_t                 code;

    sseg_pattern_decode u_decode (
        .pattern_i (seg_sync_q),
        .code_o    (code)
    );

    assign sel_act = ~sel_sync_q;
    assign onehot  = (sel_act != '0) && ((sel_act & (sel_act - SEL_ONE)) == '0);
    assign same    = (seg_sync_q == seg_prev_q) && (sel_sync_q == sel_prev_q);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_act[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (onehot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!onehot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    state_d = onehot ? ST_SETTLE : ST_IDLE;
                    cnt_d   = onehot ? CNT_ONE : '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Capture fires on the cycle the run of identical samples reaches the threshold
        if (state_q != ST_HOLD && onehot && cnt_d == CNT_MAX) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    always_comb begin
        mask_d     = mask_q;
        slots_d    = slots_q;
        frame_load = 1'b0;
        if (capture) begin
            mask_d[sel_idx]                   = 1'b1;
            slots_d[CODE_W*sel_idx +: CODE_W] = code;
            if (sel_idx == LAST_IDX && (&mask_d)) begin
                frame_load = 1'b1;
                mask_d     = '0;
            end
        end
    end

    always_comb begin
        any_inv_d = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slots_d[CODE_W*i+4 +: 2] == KIND_INVALID) any_inv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_meta_q <= '1;
            seg_sync_q <= '1;
            seg_prev_q <= '1;
            sel_meta_q <= '1;
            sel_sync_q <= '1;
            sel_prev_q <= '1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            slots_q    <= '0;
        end else begin
            seg_meta_q <= seg_in;
            seg_sync_q <= seg_meta_q;
            seg_prev_q <= seg_sync_q;
            sel_meta_q <= sel_n_in;
            sel_sync_q <= sel_meta_q;
            sel_prev_q <= sel_sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            slots_q    <= slots_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_digits_q  <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            any_invalid_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_load) begin
                out_digits_q  <= slots_d;
                out_valid_q   <= 1'b1;
                any_invalid_q <= any_inv_d;
                overrun_q     <= out_valid_q && !out_ready;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_digits  = out_digits_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign any_invalid = any_invalid_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb/tb_sseg_scan_decoder.sv - directed self-checking bench for sseg_scan_decoder
module tb_sseg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] sel_n_in;
    logic [6*ND-1:0] out_digits;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          any_invalid;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int ovr_base;

    sseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .sel_n_in    (sel_n_in),
        .out_digits  (out_digits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .any_invalid (any_invalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int cyc);
        logic [ND-1:0] s;
        s        = ~(4'b0001 << d);
        sel_n_in = s;
        seg_in   = pat;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 10);
        show(1, p1, 10);
        show(2, p2, 10);
        show(3, p3, 10);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq(tag, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        seg_in    = 7'h7F;
        sel_n_in  = '1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst out_digits", 32'(out_digits), 32'd0);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst overrun", 32'(overrun), 32'd0);
        check_eq("rst any_invalid", 32'(any_invalid), 32'd0);

        // 2, 9, minus, blank
        ovr_base = ovr_cnt;
        scan(7'b0100100, 7'b0011000, 7'b0111111, 7'b1111111);
        check_eq("t1 out_valid", 32'(out_valid), 32'd1);
        check_eq("t1 out_digits", 32'(out_digits),
                 32'({2'b10, 4'h0, 2'b01, 4'h0, 2'b00, 4'h9, 2'b00, 4'h2}));
        check_eq("t1 any_invalid", 32'(any_invalid), 32'd0);
        check_eq("t1 no overrun", 32'(ovr_cnt - ovr_base), 32'd0);
        accept("t1 accept");

        // 0, invalid 1010101, A, b
        scan(7'b1000000, 7'b1010101, 7'b0001000, 7'b0000011);
        check_eq("t2 out_valid", 32'(out_valid), 32'd1);
        check_eq("t2 out_digits", 32'(out_digits),
                 32'({2'b00, 4'hB, 2'b00, 4'hA, 2'b11, 4'h0, 2'b00, 4'h0}));
        check_eq("t2 any_invalid", 32'(any_invalid), 32'd1);
        accept("t2 accept");

        // digits 0..2 captured, digit 3 segments toggle every 3 cycles
        show(0, 7'b1111001, 10);
        show(1, 7'b0110000, 10);
        show(2, 7'b0011001, 10);
        sel_n_in = 4'b0111;
        for (int k = 0; k < 20; k++) begin
            seg_in = k[0] ? 7'b0000000 : 7'b1111111;
            repeat (3) @(negedge clk);
        end
        check_eq("t3 toggle no frame", 32'(out_valid), 32'd0);
        sel_n_in = '1;
        repeat (5) @(negedge clk);

        // two selects low: no write; digit 3 alone then completes the frame
        sel_n_in = 4'b1100;
        seg_in   = 7'b1000000;
        repeat (50) @(negedge clk);
        check_eq("t4 multi-low no frame", 32'(out_valid), 32'd0);
        show(3, 7'b0001110, 10);
        check_eq("t4 out_valid", 32'(out_valid), 32'd1);
        check_eq("t4 out_digits", 32'(out_digits),
                 32'({2'b00, 4'hF, 2'b00, 4'h4, 2'b00, 4'h3, 2'b00, 4'h1}));
        check_eq("t4 any_invalid", 32'(any_invalid), 32'd0);
        accept("t4 accept");

        // consumer stalled across two scans
        ovr_base = ovr_cnt;
        scan(7'b0100100, 7'b0011000, 7'b0111111, 7'b1111111);
        check_eq("t5 first valid", 32'(out_valid), 32'd1);
        show(0, 7'b0000010, 10);
        show(1, 7'b1111000, 10);
        check_eq("t5 held digits", 32'(out_digits),
                 32'({2'b10, 4'h0, 2'b01, 4'h0, 2'b00, 4'h9, 2'b00, 4'h2}));
        check_eq("t5 no early overrun", 32'(ovr_cnt - ovr_base), 32'd0);
        show(2, 7'b0000000, 10);
        show(3, 7'b0000110, 10);
        check_eq("t5 second valid", 32'(out_valid), 32'd1);
        check_eq("t5 second digits", 32'(out_digits),
                 32'({2'b00, 4'hE, 2'b00, 4'h8, 2'b00, 4'h7, 2'b00, 4'h6}));
        check_eq("t5 overrun pulses", 32'(ovr_cnt - ovr_base), 32'd1);
        accept("t5 accept");

        // pending frame plus partial scan, then reset
        ovr_base = ovr_cnt;
        scan(7'b1111001, 7'b0110000, 7'b0011001, 7'b0001110);
        check_eq("t6 pending valid", 32'(out_valid), 32'd1);
        show(0, 7'b0100100, 10);
        show(1, 7'b0011000, 10);
        show(2, 7'b0111111, 10);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("t6 rst out_valid", 32'(out_valid), 32'd0);
        check_eq("t6 rst out_digits", 32'(out_digits), 32'd0);
        check_eq("t6 rst any_invalid", 32'(any_invalid), 32'd0);
        check_eq("t6 rst overrun", 32'(overrun), 32'd0);
        show(3, 7'b1111111, 10);
        check_eq("t6 partial no frame", 32'(out_valid), 32'd0);
        scan(7'b0100100, 7'b0011000, 7'b0111111, 7'b1111111);
        check_eq("t6 rescan valid", 32'(out_valid), 32'd1);
        check_eq("t6 rescan digits", 32'(out_digits),
                 32'({2'b10, 4'h0, 2'b01, 4'h0, 2'b00, 4'h9, 2'b00, 4'h2}));
        check_eq("t6 no overrun", 32'(ovr_cnt - ovr_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
